// File: rtl/sc_bgctrl_pkg.sv
// Shared types and constants for the background-control sequencer.
package sc_bgctrl_pkg;

    localparam int   CNT_W_DEFAULT = 8;
    // Clear and load are active-low, so an idle output sits high.
    localparam logic OUT_INACTIVE  = 1'b1;

    typedef enum logic [2:0] {
        ST_RESET    = 3'd0,
        ST_START    = 3'd1,
        ST_CHECK    = 3'd2,
        ST_CLEAR    = 3'd3,
        ST_WAIT_REL = 3'd4,
        ST_RUN      = 3'd5
    } state_t;

endpackage

// File: rtl/sc_bgctrl_if.sv
// Front-panel button inputs and background-bank control outputs of the sequencer.
interface sc_bgctrl_if;

    logic       SC_BGCTRL_startButton_InLow;
    logic       SC_BGCTRL_pause_InLow;
    logic       SC_BGCTRL_clear_OutLow;
    logic       SC_BGCTRL_load_OutLow;
    logic       SC_BGCTRL_running_OutHigh;
    logic [2:0] SC_BGCTRL_state_Out;

    modport master (
        output SC_BGCTRL_startButton_InLow, SC_BGCTRL_pause_InLow,
        input  SC_BGCTRL_clear_OutLow, SC_BGCTRL_load_OutLow,
        input  SC_BGCTRL_running_OutHigh, SC_BGCTRL_state_Out
    );

    modport slave (
        input  SC_BGCTRL_startButton_InLow, SC_BGCTRL_pause_InLow,
        output SC_BGCTRL_clear_OutLow, SC_BGCTRL_load_OutLow,
        output SC_BGCTRL_running_OutHigh, SC_BGCTRL_state_Out
    );

endinterface

// File: rtl/sc_bgctrl_timer.sv
// Loadable down-counter with zero flag; shared by the clear and load-period phases.
module sc_bgctrl_timer
    import sc_bgctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sc_bgctrl_fsm.sv
// Background-control sequencer: clear on start press, wait for release, then periodic load strobes.
// Define SC_BGCTRL_INPUT_SYNC_EN to pass button and pause through 2-flop synchronizers.
//
// state    | meaning
// RESET    | held in reset / first cycle after release
// START    | one-cycle startup
// CHECK    | idle, waiting for a start press
// CLEAR    | clear held low for CLEAR_CYCLES cycles
// WAIT_REL | clear done, waiting for button release
// RUN      | running, periodic load strobe (pause freezes timer)
module sc_bgctrl_fsm
    import sc_bgctrl_pkg::*;
#(
    parameter int CLEAR_CYCLES = 4,
    parameter int LOAD_PERIOD  = 16,
    parameter int CNT_W        = CNT_W_DEFAULT
) (
    input  logic        SC_BGCTRL_CLOCK_50,
    input  logic        SC_BGCTRL_RESET_InLow,
    sc_bgctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] CLR_INIT  = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_PERIOD - 1);

    state_t           state_q, state_d;
    logic             btn_n, pause_n;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_val;

`ifdef SC_BGCTRL_INPUT_SYNC_EN
    logic [1:0] btn_sync_q, pause_sync_q;

    always_ff @(posedge SC_BGCTRL_CLOCK_50 or negedge SC_BGCTRL_RESET_InLow) begin
        if (!SC_BGCTRL_RESET_InLow) begin
            btn_sync_q   <= 2'b11;
            pause_sync_q <= 2'b11;
        end else begin
            btn_sync_q   <= {btn_sync_q[0], bus.SC_BGCTRL_startButton_InLow};
            pause_sync_q <= {pause_sync_q[0], bus.SC_BGCTRL_pause_InLow};
        end
    end

    assign btn_n   = btn_sync_q[1];
    assign pause_n = pause_sync_q[1];
`else
    assign btn_n   = bus.SC_BGCTRL_startButton_InLow;
    assign pause_n = bus.SC_BGCTRL_pause_InLow;
`endif

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_RESET: state_d = ST_START;
            ST_START: state_d = ST_CHECK;
            ST_CHECK: begin
                if (!btn_n) begin
                    state_d  = ST_CLEAR;
                    tmr_load = 1'b1;
                    tmr_val  = CLR_INIT;
                end
            end
            ST_CLEAR: begin
                if (tmr_zero) begin
                    state_d = ST_WAIT_REL;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_WAIT_REL: begin
                if (btn_n) begin
                    state_d  = ST_RUN;
                    tmr_load = 1'b1;
                    tmr_val  = LOAD_INIT;
                end
            end
            ST_RUN: begin
                // A press restarts the clear; a strobe due this cycle still fires via the output decode.
                if (!btn_n) begin
                    state_d  = ST_CLEAR;
                    tmr_load = 1'b1;
                    tmr_val  = CLR_INIT;
                end else if (pause_n) begin
                    if (tmr_zero) begin
                        tmr_load = 1'b1;
                        tmr_val  = LOAD_INIT;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
            end
            default: state_d = ST_CHECK;
        endcase
    end

    always_ff @(posedge SC_BGCTRL_CLOCK_50 or negedge SC_BGCTRL_RESET_InLow) begin
        if (!SC_BGCTRL_RESET_InLow) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    sc_bgctrl_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i      (SC_BGCTRL_CLOCK_50),
        .rst_n_i    (SC_BGCTRL_RESET_InLow),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    assign bus.SC_BGCTRL_clear_OutLow    = (state_q == ST_CLEAR) ? ~OUT_INACTIVE : OUT_INACTIVE;
    assign bus.SC_BGCTRL_load_OutLow     = (state_q == ST_RUN && pause_n && tmr_zero)
                                           ? ~OUT_INACTIVE : OUT_INACTIVE;
    assign bus.SC_BGCTRL_running_OutHigh = (state_q == ST_RUN);
    assign bus.SC_BGCTRL_state_Out       = state_q;

endmodule

// File: tb/tb_sc_bgctrl_fsm.sv
// Directed bench for sc_bgctrl_fsm at default parameters; adapts latencies when built with SC_BGCTRL_INPUT_SYNC_EN.
module tb_sc_bgctrl_fsm;

`ifdef SC_BGCTRL_INPUT_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    sc_bgctrl_if bus();

    sc_bgctrl_fsm dut (
        .SC_BGCTRL_CLOCK_50    (clk),
        .SC_BGCTRL_RESET_InLow (rst_n),
        .bus                   (bus)
    );

    always #5 clk = ~clk;

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [5:0] obs();
        return {bus.SC_BGCTRL_state_Out, bus.SC_BGCTRL_clear_OutLow,
                bus.SC_BGCTRL_load_OutLow, bus.SC_BGCTRL_running_OutHigh};
    endfunction

    task automatic test_reset();
        logic [2:0] exp;
        bus.SC_BGCTRL_startButton_InLow = 1'b1;
        bus.SC_BGCTRL_pause_InLow       = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (obs() !== 6'b000_110) begin
            bad++;
            $display("FAIL reset_outputs: got %b want %b", obs(), 6'b000_110);
        end
        next_cycle();
        rst_n = 1'b1;
        mid();
        total++;
        if (obs() !== 6'b000_110) begin
            bad++;
            $display("FAIL release_cycle0: got %b want %b", obs(), 6'b000_110);
        end
        for (int j = 1; j <= 10; j++) begin
            next_cycle();
            mid();
            exp = (j == 1) ? 3'd1 : 3'd2;
            total++;
            if (obs() !== {exp, 3'b110}) begin
                bad++;
                $display("FAIL idle_seq[%0d]: got %b want %b", j, obs(), {exp, 3'b110});
            end
        end
    endtask

    task automatic test_clear_run();
        int first_low = -1, n_low = 0, r = 0, sb1 = -1, sb2 = -1;
        logic [2:0] st_a = 3'd7, st_b = 3'd7;
        next_cycle();
        bus.SC_BGCTRL_startButton_InLow = 1'b0;
        mid();
        for (int i = 1; i <= 46 + S; i++) begin
            next_cycle();
            bus.SC_BGCTRL_startButton_InLow = 1'b1;
            mid();
            if (!bus.SC_BGCTRL_clear_OutLow) begin
                n_low++;
                if (first_low < 0) first_low = i;
            end
            if (i == 5 + S) st_a = bus.SC_BGCTRL_state_Out;
            if (i == 6 + S) st_b = bus.SC_BGCTRL_state_Out;
            if (bus.SC_BGCTRL_running_OutHigh) begin
                r++;
                if (!bus.SC_BGCTRL_load_OutLow) begin
                    if (sb1 < 0) sb1 = r;
                    else if (sb2 < 0) sb2 = r;
                end
            end
        end
        total++;
        if (first_low != 1 + S) begin bad++; $display("FAIL press_latency: got %0d want %0d", first_low, 1 + S); end
        total++;
        if (n_low != 4) begin bad++; $display("FAIL clear_width: got %0d want 4", n_low); end
        total++;
        if (st_a !== 3'd4) begin bad++; $display("FAIL wait_rel_state: got %0d want 4", st_a); end
        total++;
        if (st_b !== 3'd5) begin bad++; $display("FAIL run_entry: got %0d want 5", st_b); end
        total++;
        if (sb1 != 16) begin bad++; $display("FAIL first_strobe: got %0d want 16", sb1); end
        total++;
        if (sb2 != 32) begin bad++; $display("FAIL second_strobe: got %0d want 32", sb2); end
    endtask

    task automatic wait_strobe(input string tag);
        bit found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            next_cycle();
            mid();
            if (!bus.SC_BGCTRL_load_OutLow) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL %s_sync_strobe: got none want one within 20", tag); end
    endtask

    task automatic test_pause();
        int first = -1, second = -1;
        wait_strobe("pause");
        for (int k = 1; k <= 40; k++) begin
            next_cycle();
            bus.SC_BGCTRL_pause_InLow = (k >= 16 - S && k <= 20 - S) ? 1'b0 : 1'b1;
            mid();
            if (!bus.SC_BGCTRL_load_OutLow) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        bus.SC_BGCTRL_pause_InLow = 1'b1;
        total++;
        if (first != 21) begin bad++; $display("FAIL pause_resume_strobe: got %0d want 21", first); end
        total++;
        if (second != 37) begin bad++; $display("FAIL pause_next_strobe: got %0d want 37", second); end
    endtask

    task automatic test_back_to_back();
        int first_low = -1, n_low = 0;
        logic ld16 = 1'b1;
        logic [2:0] st16 = 3'd7, st21 = 3'd7, st22 = 3'd7;
        wait_strobe("restart");
        for (int k = 1; k <= 24; k++) begin
            next_cycle();
            bus.SC_BGCTRL_startButton_InLow = (k == 16 - S) ? 1'b0 : 1'b1;
            mid();
            if (k == 16) begin
                ld16 = bus.SC_BGCTRL_load_OutLow;
                st16 = bus.SC_BGCTRL_state_Out;
            end
            if (k == 21) st21 = bus.SC_BGCTRL_state_Out;
            if (k == 22) st22 = bus.SC_BGCTRL_state_Out;
            if (!bus.SC_BGCTRL_clear_OutLow) begin
                n_low++;
                if (first_low < 0) first_low = k;
            end
        end
        total++;
        if (ld16 !== 1'b0) begin bad++; $display("FAIL restart_strobe: got %b want 0", ld16); end
        total++;
        if (st16 !== 3'd5) begin bad++; $display("FAIL restart_state_at_strobe: got %0d want 5", st16); end
        total++;
        if (first_low != 17) begin bad++; $display("FAIL restart_clear_start: got %0d want 17", first_low); end
        total++;
        if (n_low != 4) begin bad++; $display("FAIL restart_clear_width: got %0d want 4", n_low); end
        total++;
        if (st21 !== 3'd4 || st22 !== 3'd5) begin
            bad++;
            $display("FAIL restart_rerun: got %0d,%0d want 4,5", st21, st22);
        end
    endtask

    task automatic test_hold();
        int first_low = -1, n_low = 0, strobes = 0;
        logic [2:0] st_w = 3'd7, st_r = 3'd7;
        for (int h = 1; h <= 12 + S; h++) begin
            next_cycle();
            bus.SC_BGCTRL_startButton_InLow = (h <= 10) ? 1'b0 : 1'b1;
            mid();
            if (!bus.SC_BGCTRL_clear_OutLow) begin
                n_low++;
                if (first_low < 0) first_low = h;
            end
            if (!bus.SC_BGCTRL_load_OutLow) strobes++;
            if (h == 11 + S) st_w = bus.SC_BGCTRL_state_Out;
            if (h == 12 + S) st_r = bus.SC_BGCTRL_state_Out;
        end
        total++;
        if (first_low != 2 + S) begin bad++; $display("FAIL hold_clear_start: got %0d want %0d", first_low, 2 + S); end
        total++;
        if (n_low != 4) begin bad++; $display("FAIL hold_clear_width: got %0d want 4", n_low); end
        total++;
        if (st_w !== 3'd4) begin bad++; $display("FAIL hold_wait_rel: got %0d want 4", st_w); end
        total++;
        if (st_r !== 3'd5) begin bad++; $display("FAIL hold_release_run: got %0d want 5", st_r); end
        total++;
        if (strobes != 0) begin bad++; $display("FAIL hold_no_strobe: got %0d want 0", strobes); end
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        int first_low = -1;
        for (int i = 0; i < 8 && !found; i++) begin
            next_cycle();
            bus.SC_BGCTRL_startButton_InLow = (i == 0) ? 1'b0 : 1'b1;
            mid();
            if (!bus.SC_BGCTRL_clear_OutLow) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL areset_enter_clear: got no clear want clear"); end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs() !== 6'b000_110) begin
            bad++;
            $display("FAIL areset_async_outputs: got %b want %b", obs(), 6'b000_110);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mid();
        total++;
        if (bus.SC_BGCTRL_state_Out !== 3'd0) begin bad++; $display("FAIL areset_rel0: got %0d want 0", bus.SC_BGCTRL_state_Out); end
        next_cycle();
        mid();
        next_cycle();
        mid();
        total++;
        if (bus.SC_BGCTRL_state_Out !== 3'd2) begin bad++; $display("FAIL areset_check: got %0d want 2", bus.SC_BGCTRL_state_Out); end
        next_cycle();
        bus.SC_BGCTRL_startButton_InLow = 1'b0;
        mid();
        for (int i = 1; i <= 6 && first_low < 0; i++) begin
            next_cycle();
            bus.SC_BGCTRL_startButton_InLow = 1'b1;
            mid();
            if (!bus.SC_BGCTRL_clear_OutLow) first_low = i;
        end
        total++;
        if (first_low != 1 + S) begin bad++; $display("FAIL areset_press_latency: got %0d want %0d", first_low, 1 + S); end
    endtask

    initial begin
        bus.SC_BGCTRL_startButton_InLow = 1'b1;
        bus.SC_BGCTRL_pause_InLow       = 1'b1;
        test_reset();
        test_clear_run();
        test_pause();
        test_back_to_back();
        test_hold();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
